// File: rtl/instr_rom_responder_if.sv
// instr_rom_responder_if: fetch port and byte-serial loader bundle (master = control unit/loader, slave = ROM responder)
interface instr_rom_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_stop;
  logic              load_busy;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  modport master (
    output fetch_req, fetch_addr, load_start, load_valid, load_byte, load_stop,
    input  instr, instr_valid, load_busy, load_done, load_count
  );
  modport slave (
    input  fetch_req, fetch_addr, load_start, load_valid, load_byte, load_stop,
    output instr, instr_valid, load_busy, load_done, load_count
  );
endinterface

// File: rtl/instr_rom_responder.sv
// instr_rom_responder: 2**ADDR_W x DATA_W instruction RAM, 1-cycle registered fetch in RUN, little-endian byte loader in LOAD; ports clk, reset (sync active-low), bus (slave)
module instr_rom_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic                   clk,
  input logic                   reset,
  instr_rom_responder_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BPW   = DATA_W / 8;
  localparam int IDX_W = BPW > 1 ? $clog2(BPW) : 1;
  typedef enum logic {RUN, LOAD} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d, merged, instr_q, instr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              valid_q, valid_d, done_q, done_d, we, rd, last;
  logic [DATA_W-1:0] mem [DEPTH];
  always_comb begin
    merged = word_q;
    merged[8*idx_q +: 8] = bus.load_byte;
    rd = state_q == RUN && bus.fetch_req && !bus.load_start;
    we = state_q == LOAD && bus.load_valid && !bus.load_stop && idx_q == IDX_W'(BPW - 1);
    last = we && &ptr_q;
    instr_d = rd ? mem[bus.fetch_addr] : instr_q;
    valid_d = rd;
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    word_d = word_q;
    count_d = count_q;
    done_d = 1'b0;
    if (state_q == RUN && bus.load_start) begin
      state_d = LOAD;
      ptr_d = '0;
      idx_d = '0;
      word_d = '0;
      count_d = '0;
    end else if (state_q == LOAD && bus.load_stop) begin
      state_d = RUN;
      idx_d = '0;
      done_d = 1'b1;
    end else if (state_q == LOAD && bus.load_valid) begin
      word_d = merged;
      idx_d = we ? '0 : idx_q + 1'b1;
      ptr_d = we ? ptr_q + 1'b1 : ptr_q;
      count_d = we ? count_q + 1'b1 : count_q;
      state_d = last ? RUN : LOAD;
      done_d = last;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      ptr_q <= '0;
      idx_q <= '0;
      word_q <= '0;
      count_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      word_q <= word_d;
      count_q <= count_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset && we) mem[ptr_q] <= merged;
  end
  assign bus.instr = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.load_busy = state_q == LOAD;
  assign bus.load_done = done_q;
  assign bus.load_count = count_q;
endmodule

// File: tb/tb_instr_rom_responder.sv
// tb_instr_rom_responder: directed scoreboard bench for instr_rom_responder
module tb_instr_rom_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  instr_rom_responder_if #(.ADDR_W(8), .DATA_W(32)) bus();
  instr_rom_responder #(.ADDR_W(8), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  int pass_n = 0;
  int fail_n = 0;
  int total_n = 0;
  logic [31:0] sb[$];
  bit fetch_exp = 1'b0;
  bit done_exp = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    bit e = fetch_exp;
    bit d = done_exp;
    fetch_exp = 1'b0;
    done_exp = 1'b0;
    @(posedge clk);
    #1;
    chk("instr_valid", 32'(bus.instr_valid), 32'(e));
    chk("load_done", 32'(bus.load_done), 32'(d));
    if (e && sb.size() > 0) chk("instr", bus.instr, sb.pop_front());
  endtask
  task automatic send(input logic [7:0] b);
    bus.load_valid = 1'b1;
    bus.load_byte = b;
    tick();
    bus.load_valid = 1'b0;
  endtask
  task automatic fetch(input logic [7:0] a, input logic [31:0] exp);
    bus.fetch_req = 1'b1;
    bus.fetch_addr = a;
    sb.push_back(exp);
    fetch_exp = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
  endtask
  task automatic start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask
  task automatic stop();
    bus.load_stop = 1'b1;
    done_exp = 1'b1;
    tick();
    bus.load_stop = 1'b0;
  endtask
  task automatic idle();
    bus.fetch_req = 1'b0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_stop = 1'b0;
  endtask
  initial begin
    logic [7:0] t2 [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    idle();
    bus.fetch_addr = '0;
    bus.load_byte = '0;
    reset = 1'b0;
    repeat (2) begin
      bus.fetch_req = 1'($urandom);
      bus.fetch_addr = 8'($urandom);
      bus.load_start = 1'($urandom);
      bus.load_valid = 1'($urandom);
      bus.load_stop = 1'($urandom);
      bus.load_byte = 8'($urandom);
      tick();
    end
    idle();
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_busy", 32'(bus.load_busy), 32'h0);
    chk("rst_count", 32'(bus.load_count), 32'h0);
    reset = 1'b1;
    start();
    chk("t2_busy", 32'(bus.load_busy), 32'h1);
    foreach (t2[i]) send(t2[i]);
    stop();
    chk("t2_count", 32'(bus.load_count), 32'd2);
    chk("t2_idle", 32'(bus.load_busy), 32'h0);
    fetch(8'd0, 32'h12345678);
    fetch(8'd1, 32'hDEADBEEF);
    tick();
    chk("t2_hold", bus.instr, 32'hDEADBEEF);
    start();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    bus.load_valid = 1'b1;
    bus.load_byte = 8'h44;
    stop();
    bus.load_valid = 1'b0;
    chk("t4_count", 32'(bus.load_count), 32'd0);
    fetch(8'd0, 32'h12345678);
    start();
    for (int i = 1; i <= 6; i++) send(8'(i));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t5_busy", 32'(bus.load_busy), 32'h0);
    chk("t5_count", 32'(bus.load_count), 32'd0);
    fetch(8'd0, 32'h04030201);
    fetch(8'd1, 32'hDEADBEEF);
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 8'd1;
    start();
    chk("t6_busy", 32'(bus.load_busy), 32'h1);
    send(8'hDD);
    send(8'hCC);
    send(8'hBB);
    send(8'hAA);
    bus.fetch_req = 1'b0;
    stop();
    chk("t6_count", 32'(bus.load_count), 32'd1);
    fetch(8'd0, 32'hAABBCCDD);
    start();
    for (int k = 0; k < 256; k++)
      for (int j = 0; j < 4; j++) begin
        if (k == 255 && j == 3) done_exp = 1'b1;
        send(8'(k));
      end
    chk("t3_busy", 32'(bus.load_busy), 32'h0);
    chk("t3_count", 32'(bus.load_count), 32'd256);
    fetch(8'd255, 32'hFFFFFFFF);
    fetch(8'd0, 32'h00000000);
    bus.load_valid = 1'b1;
    bus.load_stop = 1'b1;
    tick();
    idle();
    chk("run_ignore_count", 32'(bus.load_count), 32'd256);
    fetch(8'd1, 32'h01010101);
    fetch(8'd128, 32'h80808080);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
